prog_loader: RTL and testbench

Byte-serial program loader sitting directly upstream of the CPU core. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first to match the opcode/operand split. It writes those words into the CPU's instruction memory through a single write port and holds the CPU in reset until a complete frame with a valid checksum has been loaded.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Definitions shared by the CPU core and the program loader:
//                instruction-memory depth, derived word-address width and
//                the loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction memory depth in 16-bit words. The CPU and the loader both
    // take their depth from here so the two can never disagree.
    localparam int MEMORY_SIZE = 32;
    localparam int ADDR_W      = $clog2(MEMORY_SIZE);

    typedef enum logic [2:0] {
        ST_COUNT   = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Byte-serial program loader. Accepts a framed byte stream
//                (count N, N hi/lo word pairs, XOR checksum of the data
//                bytes), writes the assembled 16-bit words into instruction
//                memory and keeps the CPU in reset until the frame verifies.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock, all logic on posedge
//    rst        in   synchronous reset, active low
//    in_data    in   [7:0] stream byte
//    in_valid   in   in_data valid this cycle
//    in_ready   out  loader accepts a byte this cycle (state-derived only)
//    mem_we     out  one-cycle instruction-memory write strobe
//    mem_addr   out  [ADDR_W-1:0] word address for mem_we
//    mem_wdata  out  [15:0] word for mem_we, {hi, lo}
//    cpu_rst    out  active-high CPU reset, low only once the frame verifies
//    done       out  frame loaded and verified
//    error      out  frame rejected, sticky until rst
// ============================================================================
module prog_loader #(
    parameter int MEMORY_SIZE = cpu_pkg::MEMORY_SIZE,
    parameter int ADDR_W      = $clog2(MEMORY_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    import cpu_pkg::*;

    // One extra index bit so that a full-memory frame (N == MEMORY_SIZE)
    // reaches its final count without wrapping back to zero.
    localparam int         IDX_W     = ADDR_W + 1;
    localparam logic [8:0] MAX_COUNT = 9'(MEMORY_SIZE);

    loader_state_t    r_state;
    loader_state_t    w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_count;
    logic [IDX_W-1:0] w_idx_inc;
    logic [7:0]       r_hi;
    logic [7:0]       r_acc;
    logic             w_xfer;

    // ------------------------------------------------------------------
    // Next-state and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        w_xfer       = 1'b0;
        w_idx_inc    = r_idx + IDX_W'(1);
        w_state_next = r_state;

        // Ready depends on state alone so upstream may wait on it freely.
        case (r_state)
            ST_COUNT, ST_LOAD_HI, ST_LOAD_LO, ST_CHECK: in_ready = 1'b1;
            default:                                    in_ready = 1'b0;
        endcase

        w_xfer = in_valid && in_ready;

        if (w_xfer) begin
            case (r_state)
                ST_COUNT: begin
                    if ((in_data == 8'd0) || ({1'b0, in_data} > MAX_COUNT)) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_state_next = ST_LOAD_HI;
                    end
                end
                ST_LOAD_HI: w_state_next = ST_LOAD_LO;
                ST_LOAD_LO: begin
                    if (w_idx_inc == r_count) begin
                        w_state_next = ST_CHECK;
                    end else begin
                        w_state_next = ST_LOAD_HI;
                    end
                end
                ST_CHECK: begin
                    if (in_data == r_acc) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ERROR;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_COUNT;
            r_idx     <= '0;
            r_count   <= '0;
            r_hi      <= 8'd0;
            r_acc     <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 16'd0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (w_xfer) begin
                case (r_state)
                    ST_COUNT: begin
                        if (w_state_next == ST_LOAD_HI) begin
                            r_count <= IDX_W'(in_data);
                            r_idx   <= '0;
                            r_acc   <= 8'd0;
                        end
                    end
                    ST_LOAD_HI: begin
                        r_hi  <= in_data;
                        r_acc <= r_acc ^ in_data;
                    end
                    ST_LOAD_LO: begin
                        r_acc     <= r_acc ^ in_data;
                        mem_we    <= 1'b1;
                        mem_addr  <= r_idx[ADDR_W-1:0];
                        mem_wdata <= {r_hi, in_data};
                        r_idx     <= w_idx_inc;
                    end
                    default: ;
                endcase
            end

            r_state <= w_state_next;

            // Decoded from the next state so the flags move in the cycle
            // after the deciding transfer, and cpu_rst falls with done.
            done    <= (w_state_next == ST_DONE);
            error   <= (w_state_next == ST_ERROR);
            cpu_rst <= (w_state_next != ST_DONE);
        end
    end

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Expected memory writes
//                are queued as the LO bytes are driven and matched against
//                the write port as strobes appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;

    logic              clk;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    logic [ADDR_W+15:0] sb [$];
    logic [15:0]        fw [0:63];
    logic               prev_we = 1'b0;

    prog_loader #(
        .MEMORY_SIZE (MEM_DEPTH),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: every strobe must match the oldest queued write
    // and no strobe may last longer than one cycle.
    always @(negedge clk) begin
        logic [ADDR_W+15:0] exp_w;
        if (rst === 1'b1 && mem_we === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_write addr=%0d data=%h (none expected)", mem_addr, mem_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({mem_addr, mem_wdata} !== exp_w) begin
                    n_miss++;
                    $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, exp_w[ADDR_W+15:16], exp_w[15:0]);
                end
            end
            n_vec++;
            if (prev_we === 1'b1) begin
                n_miss++;
                $display("FAIL strobe_width mem_we high 2 cycles, expected 1");
            end
        end
        prev_we = mem_we;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic do_reset;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst = 1'b1;
    endtask

    task automatic go_idle;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Presents one byte and returns after the edge that accepted it.
    // With stall set, in_valid is dropped for 1-2 cycles first, carrying
    // junk data that must not be consumed.
    task automatic send_byte(input logic [7:0] b, input bit stall, input bit must_accept,
                             output bit ok, output int t_edge, output int gap);
        ok     = 1'b0;
        t_edge = -1;
        gap    = 0;
        @(negedge clk);
        if (stall) begin
            gap = $urandom_range(1, 2);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 8; t++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok     = 1'b1;
                t_edge = cyc;
                break;
            end
            @(negedge clk);
        end
        if (must_accept && !ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout byte=%h in_ready=%b expected accept", b, in_ready);
        end
    endtask

    // Sends a complete frame taken from fw[0..n-1] with the given checksum
    // byte, queuing the expected writes as the LO bytes go out.
    task automatic run_frame(input int n, input logic [7:0] chk, input bit stall,
                             output int t_cnt, output int t_chk, output int gaps);
        bit ok;
        int t;
        int g;
        gaps  = 0;
        t_chk = -1;
        send_byte(8'(n), 1'b0, 1'b1, ok, t_cnt, g);
        if (!ok) return;
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][15:8], stall, 1'b1, ok, t, g);
            gaps += g;
            if (!ok) return;
            sb.push_back({ADDR_W'(i), fw[i]});
            send_byte(fw[i][7:0], stall, 1'b1, ok, t, g);
            gaps += g;
            if (!ok) return;
        end
        n_vec++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            n_miss++;
            $display("FAIL early_release done=%b cpu_rst=%b expected done=0 cpu_rst=1", done, cpu_rst);
        end
        send_byte(chk, stall, 1'b1, ok, t_chk, g);
        gaps += g;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata, cpu_rst, done, error, in_ready} !==
            {1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_miss++;
            $display("FAIL reset_values we=%b addr=%0d wdata=%h cpu_rst=%b done=%b error=%b rdy=%b expected 0 0 0000 1 0 0 1",
                     mem_we, mem_addr, mem_wdata, cpu_rst, done, error, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_done(input string tag, input int n, input int t_cnt, input int t_chk,
                              input int gaps);
        n_vec++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0) begin
            n_miss++;
            $display("FAIL %s_flags done=%b cpu_rst=%b error=%b expected 1 0 0", tag, done, cpu_rst, error);
        end
        n_vec++;
        if (t_chk - t_cnt != 2 * n + 1 + gaps) begin
            n_miss++;
            $display("FAIL %s_latency edges=%0d expected %0d", tag, t_chk - t_cnt, 2 * n + 1 + gaps);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL %s_writes_pending left=%0d expected 0", tag, sb.size());
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL %s_ready_after in_ready=%b expected 0", tag, in_ready);
        end
    endtask

    task automatic test_good_frame;
        int  t_cnt, t_chk, gaps, t, g;
        bit  ok;
        do_reset();
        fw[0] = 16'h0803;
        fw[1] = 16'h0400;
        run_frame(2, 8'h0F, 1'b0, t_cnt, t_chk, gaps);
        check_done("good", 2, t_cnt, t_chk, gaps);
        // A byte offered in DONE must not be taken.
        send_byte(8'h55, 1'b0, 1'b0, ok, t, g);
        n_vec++;
        if (ok !== 1'b0 || done !== 1'b1) begin
            n_miss++;
            $display("FAIL done_consumes accepted=%b done=%b expected 0 1", ok, done);
        end
        go_idle();
    endtask

    task automatic test_bad_checksum;
        int t_cnt, t_chk, gaps;
        do_reset();
        fw[0] = 16'h0803;
        fw[1] = 16'h0400;
        run_frame(2, 8'h0E, 1'b0, t_cnt, t_chk, gaps);
        n_vec++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL bad_chk error=%b done=%b cpu_rst=%b rdy=%b expected 1 0 1 0",
                     error, done, cpu_rst, in_ready);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL bad_chk_writes left=%0d expected 0", sb.size());
        end
        go_idle();
        repeat (3) @(negedge clk);
        n_vec++;
        if (error !== 1'b1) begin
            n_miss++;
            $display("FAIL bad_chk_sticky error=%b expected 1", error);
        end
    endtask

    task automatic test_bad_count;
        logic [7:0] cnts [2];
        bit ok;
        int t, g;
        cnts[0] = 8'h00;
        cnts[1] = 8'h21;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            send_byte(cnts[k], 1'b0, 1'b1, ok, t, g);
            n_vec++;
            if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL bad_count_%h error=%b done=%b cpu_rst=%b rdy=%b expected 1 0 1 0",
                         cnts[k], error, done, cpu_rst, in_ready);
            end
            // Keep offering data: nothing may be consumed or written.
            repeat (4) @(negedge clk);
            go_idle();
        end
    endtask

    task automatic test_full_memory;
        int         t_cnt, t_chk, gaps;
        logic [7:0] x;
        do_reset();
        x = 8'h00;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            fw[i] = 16'($urandom);
            x     = x ^ fw[i][15:8] ^ fw[i][7:0];
        end
        run_frame(MEM_DEPTH, x, 1'b0, t_cnt, t_chk, gaps);
        check_done("full", MEM_DEPTH, t_cnt, t_chk, gaps);
        go_idle();
    endtask

    task automatic test_stalls;
        int t_cnt, t_chk, gaps;
        do_reset();
        fw[0] = 16'h0803;
        fw[1] = 16'h0400;
        run_frame(2, 8'h0F, 1'b1, t_cnt, t_chk, gaps);
        check_done("stall", 2, t_cnt, t_chk, gaps);
        go_idle();
    endtask

    task automatic test_reset_midframe;
        int  t_cnt, t_chk, gaps, t, g;
        bit  ok;
        do_reset();
        send_byte(8'd3, 1'b0, 1'b1, ok, t, g);
        send_byte(8'hAA, 1'b0, 1'b1, ok, t, g);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({mem_we, mem_addr, mem_wdata, cpu_rst, done, error, in_ready} !==
            {1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_miss++;
            $display("FAIL midframe_reset we=%b addr=%0d wdata=%h cpu_rst=%b done=%b error=%b rdy=%b expected 0 0 0000 1 0 0 1",
                     mem_we, mem_addr, mem_wdata, cpu_rst, done, error, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        fw[0] = 16'h0803;
        fw[1] = 16'h0400;
        run_frame(2, 8'h0F, 1'b0, t_cnt, t_chk, gaps);
        check_done("after_rst", 2, t_cnt, t_chk, gaps);
        go_idle();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_count();
        test_full_memory();
        test_stalls();
        test_reset_midframe();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
